flatten_index_rom: RTL and testbench
====================================

# flatten_index_rom

Read-only index table for the CNN flatten stage. It converts a sequential flattened-output position into the address of that element in the flatten buffer. The buffer is channel-major: 32 channel planes of 49 pixels each, 1568 entries. The output ordering is pixel-major / channel-minor (channels-last flatten). The table is read by `flatten1` once per output cycle; its 11-bit output drives the buffer read address directly.

## Interface
Parameters:
- `CH`, default 32: channel count; must be a power of two.
- `PIX`, default 49: pixels per channel plane (7×7).
- `AW`, default 11: address width.
- `DW`, default 11: data width.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `en`, input, 1: read enable.
- `addr`, input, AW: flattened output position k, 0…CH·PIX−1.
- `data`, output, DW, registered: buffer address for position k.

## Operation
- Depth `DEPTH = CH·PIX` = 1568.
- For `addr = k < DEPTH`:
  - channel `c = k mod CH`, which is `addr[4:0]`.
  - pixel `p = k / CH`, which is `addr[10:5]`.
  - `data = c·PIX + p`.
- For `addr ≥ DEPTH`: `data = 0`. This covers wrapped and negative addresses from the caller's `cou1−50` computation.
- The mapping is computed combinationally from `addr`. Either a shift-add (`c·49 = (c<<5)+(c<<4)+c`) or a generated constant table is acceptable; the result must be bit-identical.
- All arithmetic is unsigned. Intermediate sums are at least 11 bits, so nothing truncates: the maximum value is 31·49+48 = 1567.
- There are no writable entries and no internal state except the output register.

## Timing
- Reset (`rst` = 0, asynchronous): `data` becomes 0 immediately and stays 0 while reset is held.
- Latency: `addr` is sampled on the rising edge where `en` = 1, and `data` shows the result after that edge (1 cycle).
- `en` = 0: `data` holds its last value.
- A new address may be presented every cycle (full throughput).
- Reset asserted mid-stream: `data` clears to 0 at once. The first valid read after release is at the first rising edge with `rst` = 1 and `en` = 1.
- Reset deassertion is synchronised externally.

## Configuration
- Macro `FLATTEN_ROM_VALID_EN`.
- Defined: adds output port `valid` (1 bit).
  - `valid` is `en` registered on the same edge as `data`.
  - `valid` is 0 in reset.
  - `valid` is 0 for a cycle in which an out-of-range address was sampled.
- Undefined: no `valid` port. `data` behaviour is unchanged.

## Structure
- Shared package `cnn_flatten_pkg` holds:
  - `FLAT_CH` = 32, `FLAT_PIX` = 49, `FLAT_DEPTH` = 1568;
  - `FLAT_AW` = 11;
  - the typedef `flat_addr_t` (logic [10:0]).
- One sub-module is natural: `flat_index_map`, the pure combinational `k → c·PIX + p` function including the range check. The top wraps it with the enable and output register.

## Test plan
- Apply `rst` = 0, then release it → `data` = 0 (and `valid` = 0) before the first enabled edge.
- `en` = 1 with `addr` = 0, 1, 31, 32, 33 on consecutive cycles → `data` = 0, 49, 1519, 1, 50, each one cycle later.
- `addr` = 1567 → 1567; `addr` = 1536 → 48; `addr` = 1568 and 2047 → 0 (`valid` = 0 when the macro is defined).
- Sweep `addr` 0…1567 with `en` = 1 → every output is distinct and the set is exactly 0…1567 (a permutation).
- Read `addr` = 5 (→ 245), then hold `en` = 0 while changing `addr` → `data` stays 245.
- Assert `rst` asynchronously mid-sweep, between clock edges → `data` = 0 without waiting for a clock edge. After release with `en` = 1 and `addr` = 2 → 98.

Source files
------------

// File: rtl/cnn_flatten_pkg.sv
// Shared constants and types for the CNN flatten stage.
// The flatten buffer is channel-major: FLAT_CH planes of FLAT_PIX pixels each.
package cnn_flatten_pkg;

    localparam int unsigned FLAT_CH    = 32;
    localparam int unsigned FLAT_PIX   = 49;
    localparam int unsigned FLAT_DEPTH = FLAT_CH * FLAT_PIX;
    localparam int unsigned FLAT_AW    = 11;
    localparam int unsigned FLAT_DW    = 11;

    typedef logic [10:0] flat_addr_t;

endpackage

// File: rtl/flatten_index_rom_if.sv
// Read port of the flatten index table: enable, position, buffer address.
// Macro FLATTEN_ROM_VALID_EN adds a registered valid flag.
interface flatten_index_rom_if
    import cnn_flatten_pkg::*;
#(
    parameter int unsigned AW = FLAT_AW,
    parameter int unsigned DW = FLAT_DW
);

    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
`ifdef FLATTEN_ROM_VALID_EN
    logic          valid;
`endif

`ifdef FLATTEN_ROM_VALID_EN
    modport master (output en, output addr, input data, input valid);
    modport slave  (input en, input addr, output data, output valid);
`else
    modport master (output en, output addr, input data);
    modport slave  (input en, input addr, output data);
`endif

endinterface

// File: rtl/flat_index_map.sv
// Pure combinational map from flattened position k (channels-last order)
// to the channel-major buffer address c*PIX + p. Out-of-range k maps to 0.
module flat_index_map
    import cnn_flatten_pkg::*;
#(
    parameter int unsigned CH  = FLAT_CH,
    parameter int unsigned PIX = FLAT_PIX,
    parameter int unsigned AW  = FLAT_AW,
    parameter int unsigned DW  = FLAT_DW
) (
    input  logic [AW-1:0] k,
    output logic [DW-1:0] idx,
    output logic          in_range
);

    // CH is a power of two, so channel and pixel are plain bit fields of k.
    localparam int unsigned CW = $clog2(CH);
    localparam int unsigned PW = AW - CW;

    localparam logic [AW:0]   DEPTH = (AW + 1)'(CH * PIX);
    localparam logic [DW-1:0] PIX_W = DW'(PIX);

    logic [CW-1:0] chan;
    logic [PW-1:0] pix;
    logic [DW-1:0] sum;

    assign chan = k[CW-1:0];
    assign pix  = k[AW-1:CW];

    // Range check and address arithmetic; sum is wide enough for c*PIX + p.
    always_comb begin
        in_range = ({1'b0, k} < DEPTH);
        sum      = DW'(chan) * PIX_W + DW'(pix);
        idx      = in_range ? sum : '0;
    end

endmodule

// File: rtl/flatten_index_rom.sv
// Read-only flatten index table: registered lookup of the buffer address
// for flattened output position addr, one read per cycle.
// Macro FLATTEN_ROM_VALID_EN adds bus.valid (en registered, low when the
// sampled address was out of range).
module flatten_index_rom
    import cnn_flatten_pkg::*;
#(
    parameter int unsigned CH  = FLAT_CH,
    parameter int unsigned PIX = FLAT_PIX,
    parameter int unsigned AW  = FLAT_AW,
    parameter int unsigned DW  = FLAT_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    flatten_index_rom_if.slave        bus
);

    logic [DW-1:0] idx;
    logic          in_range;
    logic [DW-1:0] data_q;

    flat_index_map #(
        .CH  (CH),
        .PIX (PIX),
        .AW  (AW),
        .DW  (DW)
    ) u_map (
        .k        (bus.addr),
        .idx      (idx),
        .in_range (in_range)
    );

    // Output register: load on enable, hold otherwise, clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (bus.en) begin
            data_q <= idx;
        end
    end

    assign bus.data = data_q;

`ifdef FLATTEN_ROM_VALID_EN
    logic valid_q;

    // Valid flag: follows en each cycle, suppressed for out-of-range reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.en & in_range;
        end
    end

    assign bus.valid = valid_q;
`else
    logic unused_in_range;
    assign unused_in_range = in_range;
`endif

endmodule

// File: tb/tb_flatten_index_rom.sv
// Scoreboard bench for flatten_index_rom: stimulus pushes expected results,
// a monitor pops and compares one cycle after every enabled edge.
module tb_flatten_index_rom;

    localparam int DEPTH = 1568;

    typedef struct {
        int addr;
        int exp_data;
        bit exp_valid;
        bit inv;
    } item_t;

    logic clk;
    logic rst;

    flatten_index_rom_if #(.AW(11), .DW(11)) bus ();

    flatten_index_rom dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    item_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    seen[DEPTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_checks++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic read(input int a, input int exp, input bit vld);
        item_t it;
        @(negedge clk);
        bus.en   = 1'b1;
        bus.addr = 11'(a);
        it.addr      = a;
        it.exp_data  = exp;
        it.exp_valid = vld;
        it.inv       = 1'b0;
        sb.push_back(it);
    endtask

    task automatic read_inv(input int a);
        item_t it;
        @(negedge clk);
        bus.en   = 1'b1;
        bus.addr = 11'(a);
        it.addr      = a;
        it.exp_data  = 0;
        it.exp_valid = 1'b1;
        it.inv       = 1'b1;
        sb.push_back(it);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    // Monitor: every enabled, out-of-reset edge must have a queued expectation.
    initial begin
        logic  en_s;
        logic  rst_s;
        item_t it;
        int    d;
        forever begin
            @(posedge clk);
            en_s  = bus.en;
            rst_s = rst;
            #1;
            if (en_s && rst_s) begin
                if (sb.size() == 0) begin
                    fail_now("sb_underflow", 0, 1);
                end else begin
                    it = sb.pop_front();
                    d  = int'(bus.data);
                    if (it.inv) begin
                        // Inverse model: decode buffer address back to position.
                        if (d < DEPTH) begin
                            check($sformatf("sweep_inv[%0d]", it.addr),
                                  (d % 49) * 32 + (d / 49), it.addr);
                            seen[d]++;
                        end else begin
                            fail_now($sformatf("sweep_range[%0d]", it.addr), d, DEPTH - 1);
                        end
                    end else begin
                        check($sformatf("data[%0d]", it.addr), d, it.exp_data);
                    end
`ifdef FLATTEN_ROM_VALID_EN
                    check($sformatf("valid[%0d]", it.addr), int'(bus.valid),
                          int'(it.exp_valid));
`endif
                end
            end
        end
    end

    initial begin
        int dup_or_missing;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.addr = '0;
        foreach (seen[i]) seen[i] = 0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b0;
        #1 check("reset_async_data", int'(bus.data), 0);
        repeat (2) @(posedge clk);
        #1 check("reset_held_data", int'(bus.data), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("post_reset_data", int'(bus.data), 0);
`ifdef FLATTEN_ROM_VALID_EN
        check("post_reset_valid", int'(bus.valid), 0);
`endif

        // Directed vectors, back to back.
        read(0,    0,    1'b1);
        read(1,    49,   1'b1);
        read(31,   1519, 1'b1);
        read(32,   1,    1'b1);
        read(33,   50,   1'b1);
        read(1567, 1567, 1'b1);
        read(1536, 48,   1'b1);
        read(1568, 0,    1'b0);
        read(100,  199,  1'b1);
        read(2047, 0,    1'b0);
        read(41,   442,  1'b1);
        idle();

        // Full sweep; results must form a permutation of 0..DEPTH-1.
        for (int k = 0; k < DEPTH; k++) read_inv(k);
        idle();
        @(posedge clk);
        #2;
        dup_or_missing = 0;
        foreach (seen[i]) if (seen[i] != 1) dup_or_missing++;
        check("sweep_permutation_bad_entries", dup_or_missing, 0);

        // Hold: en low keeps the last value while addr moves.
        read(5, 245, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.en   = 1'b0;
            bus.addr = 11'(7 + 300 * i);
            @(posedge clk);
            #2 check($sformatf("hold_data[%0d]", i), int'(bus.data), 245);
`ifdef FLATTEN_ROM_VALID_EN
            check($sformatf("hold_valid[%0d]", i), int'(bus.valid), 0);
`endif
        end

        // Reset mid-stream, between edges.
        read(40,   393, 1'b1);
        read(1567, 1567, 1'b1);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        bus.en = 1'b0;
        #1 check("midstream_reset_data", int'(bus.data), 0);
`ifdef FLATTEN_ROM_VALID_EN
        check("midstream_reset_valid", int'(bus.valid), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        read(2, 98, 1'b1);
        idle();
        @(posedge clk);
        #2 check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
